time_keeper: RTL and testbench

//  Running 12-hour time-of-day counter downstream of the time-set mode stage.

---
 rtl/time_keeper_pkg.sv | 24 ++
 rtl/sec_prescaler.sv | 38 +++
 rtl/time_keeper.sv | 116 +++++++++++
 tb/tb_time_keeper.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_keeper_pkg.sv
// Shared clock definitions: UI mode codes, time field limits, FSM state codes
// and a field clamp helper used when loading edited time.
package time_keeper_pkg;

  localparam logic [3:0] MODE_TIME      = 4'b0000;
  localparam logic [3:0] MODE_TIME_SET  = 4'b0001;
  localparam logic [3:0] MODE_ALARM     = 4'b0010;
  localparam logic [3:0] MODE_STOPWATCH = 4'b0100;
  localparam logic [3:0] MODE_ALARM_SET = 4'b1000;

  localparam logic [6:0] SEC_MAX  = 7'd59;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] HOUR_MAX = 7'd11;

  localparam logic [1:0] StRun  = 2'd0;
  localparam logic [1:0] StSet  = 2'd1;
  localparam logic [1:0] StLoad = 2'd2;

  // Out-of-range edited values load as zero rather than saturating.
  function automatic logic [6:0] clamp_field(input logic [6:0] val, input logic [6:0] max_val);
    return (val > max_val) ? 7'd0 : val;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides the system clock down to a one-per-second tick; shared with the stopwatch.
// TICK is combinational and high in the cycle the counter sits at its terminal value.
module sec_prescaler #(
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] Term = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    TICK  = 1'b0;
    if (CLR) begin
      cnt_d = '0;
    end else if (EN) begin
      if (cnt_q == Term) begin
        cnt_d = '0;
        TICK  = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/time_keeper.sv
// 12-hour time-of-day counter: counts in RUN, freezes in SET, and loads the
// edited time through a single LOAD cycle when time-set mode is left.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 1000,
  parameter logic [3:0]  SET_MODE = MODE_TIME_SET
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] MODE,
  input  logic       SET_MERIDIEM,
  input  logic [6:0] SET_HOUR,
  input  logic [6:0] SET_MIN,
  input  logic [6:0] SET_SEC,
  output logic       MERIDIEM,
  output logic [6:0] HOUR,
  output logic [6:0] MIN,
  output logic [6:0] SEC,
  output logic       TICK,
  output logic       HALFDAY
);

  logic [1:0] state_d, state_q;
  logic       meridiem_d, meridiem_q;
  logic [6:0] hour_d, hour_q, min_d, min_q, sec_d, sec_q;
  logic       tick_d, tick_q, halfday_d, halfday_q;
  logic       ps_en, ps_tick;

  assign ps_en = (state_q == StRun);

  sec_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .CLK  (CLK),
    .RESET(RESET),
    .EN   (ps_en),
    .CLR  (~ps_en),
    .TICK (ps_tick)
  );

  always_comb begin
    state_d    = state_q;
    meridiem_d = meridiem_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    tick_d     = 1'b0;
    halfday_d  = 1'b0;
    case (state_q)
      StRun: begin
        if (MODE == SET_MODE) state_d = StSet;
        // A terminal-cycle tick is still taken when SET is requested alongside it.
        if (ps_tick) begin
          tick_d = 1'b1;
          if (sec_q < SEC_MAX) begin
            sec_d = sec_q + 7'd1;
          end else begin
            sec_d = 7'd0;
            if (min_q < MIN_MAX) begin
              min_d = min_q + 7'd1;
            end else begin
              min_d = 7'd0;
              if (hour_q < HOUR_MAX) begin
                hour_d = hour_q + 7'd1;
              end else begin
                hour_d     = 7'd0;
                meridiem_d = ~meridiem_q;
                halfday_d  = 1'b1;
              end
            end
          end
        end
      end
      StSet: begin
        if (MODE != SET_MODE) state_d = StLoad;
      end
      StLoad: begin
        meridiem_d = SET_MERIDIEM;
        hour_d     = clamp_field(SET_HOUR, HOUR_MAX);
        min_d      = clamp_field(SET_MIN, MIN_MAX);
        sec_d      = clamp_field(SET_SEC, SEC_MAX);
        state_d    = (MODE == SET_MODE) ? StSet : StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StRun;
      meridiem_q <= 1'b0;
      hour_q     <= 7'd0;
      min_q      <= 7'd0;
      sec_q      <= 7'd0;
      tick_q     <= 1'b0;
      halfday_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      meridiem_q <= meridiem_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      tick_q     <= tick_d;
      halfday_q  <= halfday_d;
    end
  end

  assign MERIDIEM = meridiem_q;
  assign HOUR     = hour_q;
  assign MIN      = min_q;
  assign SEC      = sec_q;
  assign TICK     = tick_q;
  assign HALFDAY  = halfday_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with a 4-clock second; times are packed as
// {meridiem, hour, min, sec} for comparison.
module tb_time_keeper;

  localparam int unsigned ClkDiv = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mode;
  logic       set_m;
  logic [6:0] set_h, set_mi, set_s;
  logic       meridiem;
  logic [6:0] hour, min_v, sec;
  logic       tick, halfday;
  logic [21:0] now_t;

  int checks   = 0;
  int failures = 0;

  assign now_t = {meridiem, hour, min_v, sec};

  time_keeper #(
    .CLK_DIV (ClkDiv),
    .SET_MODE(4'b0001)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .MODE        (mode),
    .SET_MERIDIEM(set_m),
    .SET_HOUR    (set_h),
    .SET_MIN     (set_mi),
    .SET_SEC     (set_s),
    .MERIDIEM    (meridiem),
    .HOUR        (hour),
    .MIN         (min_v),
    .SEC         (sec),
    .TICK        (tick),
    .HALFDAY     (halfday)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] tm(input logic m, input int h, input int mi, input int s);
    return {m, 7'(h), 7'(mi), 7'(s)};
  endfunction

  // Reference time advance for one second.
  function automatic logic [21:0] adv(input logic [21:0] t);
    logic m;
    int   h, mi, s;
    m  = t[21];
    h  = int'(t[20:14]);
    mi = int'(t[13:7]);
    s  = int'(t[6:0]);
    s++;
    if (s == 60) begin
      s = 0;
      mi++;
      if (mi == 60) begin
        mi = 0;
        h++;
        if (h == 12) begin
          h = 0;
          m = ~m;
        end
      end
    end
    return tm(m, h, mi, s);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Enter SET, present the edited time, leave SET; returns one cycle after LOAD.
  task automatic do_load(input logic m, input int h, input int mi, input int s);
    set_m  = m;
    set_h  = 7'(h);
    set_mi = 7'(mi);
    set_s  = 7'(s);
    mode   = 4'b0001;
    step(1);
    mode = 4'b0000;
    step(2);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    checks++;
    if (now_t !== tm(0, 0, 0, 0) || tick !== 1'b0 || halfday !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%h tick=%b hd=%b want=%h tick=0 hd=0",
               now_t, tick, halfday, tm(0, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid;
    do_load(1, 3, 25, 17);
    checks++;
    if (now_t !== tm(1, 3, 25, 17)) begin
      failures++;
      $display("FAIL mid_load got=%h want=%h", now_t, tm(1, 3, 25, 17));
    end
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (now_t !== tm(0, 0, 0, 0) || tick !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%h tick=%b want=%h tick=0", now_t, tick, tm(0, 0, 0, 0));
    end
    step(3);
    checks++;
    if (tick !== 1'b0 || sec !== 7'd0) begin
      failures++;
      $display("FAIL reset_early_tick tick=%b sec=%0d want tick=0 sec=0", tick, sec);
    end
    step(1);
    checks++;
    if (tick !== 1'b1 || sec !== 7'd1) begin
      failures++;
      $display("FAIL reset_first_tick tick=%b sec=%0d want tick=1 sec=1", tick, sec);
    end
  endtask

  task automatic test_rollover;
    do_load(1, 11, 59, 59);
    step(3);
    checks++;
    if (now_t !== tm(1, 11, 59, 59) || tick !== 1'b0) begin
      failures++;
      $display("FAIL roll_pre got=%h tick=%b want=%h tick=0", now_t, tick, tm(1, 11, 59, 59));
    end
    step(1);
    checks++;
    if (now_t !== tm(0, 0, 0, 0) || tick !== 1'b1 || halfday !== 1'b1) begin
      failures++;
      $display("FAIL roll_pm_am got=%h tick=%b hd=%b want=%h tick=1 hd=1",
               now_t, tick, halfday, tm(0, 0, 0, 0));
    end
    step(1);
    checks++;
    if (tick !== 1'b0 || halfday !== 1'b0) begin
      failures++;
      $display("FAIL roll_pulse_width tick=%b hd=%b want tick=0 hd=0", tick, halfday);
    end
    do_load(0, 11, 59, 59);
    step(4);
    checks++;
    if (now_t !== tm(1, 0, 0, 0) || halfday !== 1'b1) begin
      failures++;
      $display("FAIL roll_am_pm got=%h hd=%b want=%h hd=1", now_t, halfday, tm(1, 0, 0, 0));
    end
  endtask

  task automatic test_set_load;
    int bad;
    do_load(0, 1, 2, 3);
    mode = 4'b0001;
    bad  = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (now_t !== tm(0, 1, 2, 3) || tick !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL set_frozen got=%h tick=%b bad_cycles=%0d want=%h tick=0 bad_cycles=0",
               now_t, tick, bad, tm(0, 1, 2, 3));
    end
    set_m  = 1'b1;
    set_h  = 7'd7;
    set_mi = 7'd45;
    set_s  = 7'd30;
    mode   = 4'b0000;
    step(1);
    checks++;
    if (now_t !== tm(0, 1, 2, 3)) begin
      failures++;
      $display("FAIL load_cycle_hold got=%h want=%h", now_t, tm(0, 1, 2, 3));
    end
    step(1);
    checks++;
    if (now_t !== tm(1, 7, 45, 30) || tick !== 1'b0) begin
      failures++;
      $display("FAIL load_value got=%h tick=%b want=%h tick=0", now_t, tick, tm(1, 7, 45, 30));
    end
    step(3);
    checks++;
    if (sec !== 7'd30) begin
      failures++;
      $display("FAIL load_early_tick sec=%0d want=30", sec);
    end
    step(1);
    checks++;
    if (sec !== 7'd31 || tick !== 1'b1) begin
      failures++;
      $display("FAIL load_first_tick sec=%0d tick=%b want sec=31 tick=1", sec, tick);
    end
  endtask

  task automatic test_clamp;
    do_load(0, 12, 60, 99);
    checks++;
    if (now_t !== tm(0, 0, 0, 0)) begin
      failures++;
      $display("FAIL clamp_all got=%h want=%h", now_t, tm(0, 0, 0, 0));
    end
    do_load(1, 127, 59, 60);
    checks++;
    if (now_t !== tm(1, 0, 59, 0)) begin
      failures++;
      $display("FAIL clamp_mixed got=%h want=%h", now_t, tm(1, 0, 59, 0));
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    do_load(0, 5, 10, 20);
    step(3);
    mode = 4'b0001;
    step(1);
    checks++;
    if (now_t !== tm(0, 5, 10, 21) || tick !== 1'b1) begin
      failures++;
      $display("FAIL race_tick got=%h tick=%b want=%h tick=1", now_t, tick, tm(0, 5, 10, 21));
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (now_t !== tm(0, 5, 10, 21) || tick !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL race_hold bad_cycles=%0d want=0", bad);
    end
    set_m  = 1'b1;
    set_h  = 7'd2;
    set_mi = 7'd33;
    set_s  = 7'd44;
    mode   = 4'b0000;
    step(1);
    mode = 4'b0001;
    step(1);
    checks++;
    if (now_t !== tm(1, 2, 33, 44)) begin
      failures++;
      $display("FAIL toggle_load got=%h want=%h", now_t, tm(1, 2, 33, 44));
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (now_t !== tm(1, 2, 33, 44) || tick !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL toggle_back_to_set bad_cycles=%0d want=0", bad);
    end
    mode = 4'b0100;
    step(2);
    step(4);
    checks++;
    if (now_t !== tm(1, 2, 33, 45)) begin
      failures++;
      $display("FAIL other_mode_counts got=%h want=%h", now_t, tm(1, 2, 33, 45));
    end
    mode = 4'b0000;
  endtask

  task automatic soak_segment(input logic m, inout int hd_cnt);
    logic [21:0] exp_t;
    int          bad_range, bad_time;
    do_load(m, 11, 0, 0);
    exp_t     = tm(m, 11, 0, 0);
    bad_range = 0;
    bad_time  = 0;
    for (int i = 0; i < 3600; i++) begin
      for (int c = 0; c < ClkDiv; c++) begin
        step(1);
        if (sec > 7'd59 || min_v > 7'd59 || hour > 7'd11) bad_range++;
        if (halfday === 1'b1) hd_cnt++;
        if (c == ClkDiv - 1) begin
          exp_t = adv(exp_t);
          if (tick !== 1'b1 || now_t !== exp_t) bad_time++;
        end else if (tick !== 1'b0) begin
          bad_time++;
        end
      end
    end
    checks++;
    if (bad_range != 0) begin
      failures++;
      $display("FAIL soak_range bad_cycles=%0d want=0", bad_range);
    end
    checks++;
    if (bad_time != 0) begin
      failures++;
      $display("FAIL soak_count bad_ticks=%0d last got=%h want=%h", bad_time, now_t, exp_t);
    end
  endtask

  task automatic test_soak;
    int hd_cnt;
    hd_cnt = 0;
    soak_segment(1'b0, hd_cnt);
    soak_segment(1'b1, hd_cnt);
    checks++;
    if (now_t !== tm(0, 0, 0, 0)) begin
      failures++;
      $display("FAIL soak_end got=%h want=%h", now_t, tm(0, 0, 0, 0));
    end
    checks++;
    if (hd_cnt != 2) begin
      failures++;
      $display("FAIL soak_halfday got=%0d want=2", hd_cnt);
    end
  endtask

  initial begin
    rst    = 1'b1;
    mode   = 4'b0000;
    set_m  = 1'b0;
    set_h  = 7'd0;
    set_mi = 7'd0;
    set_s  = 7'd0;
    test_reset;
    test_reset_mid;
    test_rollover;
    test_set_load;
    test_clamp;
    test_back_to_back;
    test_soak;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
